// File: rtl/bcd_serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// bcd_serial_add_ctrl
//   Digit-serial packed-BCD adder. One shared single-digit BCD add stage is
//   stepped over the DIGITS digits of the latched operands, least significant
//   digit first, with the decimal carry held in a register between digits.
//   The result is held on the output side until the sink accepts it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operand pair presented by the source
//   in_ready   controller can accept operands (only while idle)
//   a, b       packed-BCD operands, digit 0 in bits [3:0]
//   cin        decimal carry into digit 0
//   out_valid  result is held and valid
//   out_ready  sink accepts the result
//   sum        packed-BCD sum
//   cout       decimal carry out of the top digit
//   bcd_err    at least one digit of a or b was above 9
//
// Timing: accept edge, then DIGITS digit edges; out_valid rises DIGITS+1
// cycles after the accept cycle. One extra edge is spent handing the result
// to the sink, so back-to-back throughput is one add per DIGITS+2 cycles.
// ----------------------------------------------------------------------------
module bcd_serial_add_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  bcd_err
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [W-1:0]     sum_q;
  logic             cout_q;
  logic             bcd_err_q;

  // Single-digit BCD add stage on the currently selected digit pair
  logic [3:0] a_dig;
  logic [3:0] b_dig;
  logic [4:0] raw;
  logic       raw_gt9;
  logic [3:0] dig_d;
  logic       carry_d;
  logic       dig_err;

  always_comb begin
    a_dig   = a_q[4*idx_q +: 4];
    b_dig   = b_q[4*idx_q +: 4];
    raw     = 5'(a_dig) + 5'(b_dig) + 5'(carry_q);
    raw_gt9 = (raw > 5'd9);
    // +6 skips the six unused codes; only the low nibble is kept, so
    // invalid-digit inputs wrap rather than saturate
    dig_d   = raw_gt9 ? (raw[3:0] + 4'd6) : raw[3:0];
    carry_d = raw_gt9;
    dig_err = (a_dig > 4'd9) || (b_dig > 4'd9);
  end

  // Sequencer: accept, step digits, hold result until the sink takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      bcd_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            carry_q    <= cin;
            sum_q      <= '0;
            bcd_err_q  <= 1'b0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_RUN;
          end
        end

        ST_RUN: begin
          sum_q[4*idx_q +: 4] <= dig_d;
          carry_q             <= carry_d;
          bcd_err_q           <= bcd_err_q | dig_err;
          if (idx_q == LAST_IDX) begin
            cout_q      <= carry_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign bcd_err   = bcd_err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bcd_serial_add_ctrl
//   Scoreboarded bench for bcd_serial_add_ctrl (DIGITS=4). The driver pushes
//   the expected result at every accept edge; a negedge monitor pops and
//   compares on every output handshake. Expected values come from decimal
//   integer arithmetic (or the per-digit rule for invalid-BCD operands).
// ----------------------------------------------------------------------------
module tb_bcd_serial_add_ctrl;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         bcd_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  exp_t exp_q[$];
  int   xfer_q[$];

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .bcd_err  (bcd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: decimal integer add for valid BCD, digit rule otherwise
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c);
    exp_t r;
    int   ai, bi, s, lim, carry, raw;
    logic [W-1:0] wa, wb;
    bit   ok;
    wa = av;
    wb = bv;
    ok = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++)
      if (wa[4*i +: 4] > 4'd9 || wb[4*i +: 4] > 4'd9) ok = 1'b0;
    r.err = !ok;
    r.sum = '0;
    if (ok) begin
      ai = 0; bi = 0; lim = 1;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
        ai = ai * 10 + int'(wa[4*i +: 4]);
        bi = bi * 10 + int'(wb[4*i +: 4]);
      end
      for (int i = 0; i < int'(DIGITS); i++) lim = lim * 10;
      s      = ai + bi + int'(c);
      r.cout = (s >= lim);
      s      = s % lim;
      for (int i = 0; i < int'(DIGITS); i++) begin
        r.sum[4*i +: 4] = 4'(s % 10);
        s = s / 10;
      end
    end else begin
      carry = int'(c);
      for (int i = 0; i < int'(DIGITS); i++) begin
        raw = int'(wa[4*i +: 4]) + int'(wb[4*i +: 4]) + carry;
        if (raw > 9) begin
          r.sum[4*i +: 4] = 4'((raw + 6) % 16);
          carry = 1;
        end else begin
          r.sum[4*i +: 4] = 4'(raw);
          carry = 0;
        end
      end
      r.cout = (carry != 0);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] v;
    for (int i = 0; i < int'(DIGITS); i++)
      v[4*i +: 4] = allow_bad ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Monitor: a handshake seen at negedge completes at the next posedge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      xfer_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: got sum 0x%0h with nothing expected", sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_sum", 32'(sum), 32'(e.sum));
        chk("result_cout", 32'(cout), 32'(e.cout));
        chk("result_bcd_err", 32'(bcd_err), 32'(e.err));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands, wait for acceptance, then scramble the bus
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c, input bit push);
    int n;
    in_valid = 1'b1;
    a = av;
    b = bv;
    cin = c;
    n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", 32'(1), 32'(0));
    end else begin
      @(posedge clk);
      if (push) exp_q.push_back(model(av, bv, c));
      #1;
    end
    in_valid = 1'b0;
    a   = rand_bcd(1'b1);
    b   = rand_bcd(1'b1);
    cin = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) chk("drain_timeout", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           n;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    // reset state
    chk("reset_in_ready", 32'(in_ready), 32'(1));
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_sum", 32'(sum), 32'(0));
    chk("reset_cout", 32'(cout), 32'(0));
    chk("reset_bcd_err", 32'(bcd_err), 32'(0));

    // 45 + 37, with latency check
    send(16'h0045, 16'h0037, 1'b0, 1'b1);
    for (int k = 0; k <= int'(DIGITS); k++) begin
      chk($sformatf("latency_out_valid_k%0d", k), 32'(out_valid), (k == int'(DIGITS)) ? 32'(1) : 32'(0));
      if (k < int'(DIGITS)) step();
    end
    out_ready = 1'b1;
    drain();

    // carry ripple through all digits
    send(16'h9999, 16'h0001, 1'b0, 1'b1);
    drain();
    send(16'h9999, 16'h9999, 1'b1, 1'b1);
    drain();

    // invalid BCD digit
    send(16'h00A3, 16'h0001, 1'b0, 1'b1);
    drain();

    // sink stall: result held, no new accept
    out_ready = 1'b0;
    send(16'h0512, 16'h0389, 1'b1, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk("stall_reach_done", 32'(out_valid), 32'(1));
    held = sum;
    in_valid = 1'b1;
    a = 16'h1111;
    b = 16'h2222;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("stall_out_valid", 32'(out_valid), 32'(1));
      chk("stall_sum_stable", 32'(sum), 32'(held));
      chk("stall_in_ready", 32'(in_ready), 32'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("release_in_ready", 32'(in_ready), 32'(1));
    chk("release_out_valid", 32'(out_valid), 32'(0));
    drain();

    // reset on the second RUN cycle aborts the add
    send(16'h0777, 16'h0888, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_out_valid", 32'(out_valid), 32'(0));
    chk("abort_sum", 32'(sum), 32'(0));
    chk("abort_in_ready", 32'(in_ready), 32'(1));
    chk("abort_cout", 32'(cout), 32'(0));
    chk("abort_bcd_err", 32'(bcd_err), 32'(0));
    send(16'h1234, 16'h4321, 1'b0, 1'b1);
    drain();

    // back-to-back random valid operands, throughput check
    xfer_q.delete();
    for (int k = 0; k < 8; k++) begin
      ra = rand_bcd(1'b0);
      rb = rand_bcd(1'b0);
      send(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
    end
    drain();
    chk("throughput_count", 32'(xfer_q.size()), 32'(8));
    for (int k = 1; k < xfer_q.size(); k++)
      chk($sformatf("throughput_gap%0d", k), 32'(xfer_q[k] - xfer_q[k-1]), 32'(DIGITS + 2));

    // random operands that may contain invalid digits
    for (int k = 0; k < 12; k++) begin
      ra = rand_bcd(1'b1);
      rb = rand_bcd(1'b1);
      send(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
    end
    drain();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
